// File: rtl/wb_master_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : wb_master_arbiter                                           |
// | Description : Arbiter/sequencer sharing one Wishbone master interface     |
// |               between NREQ requesters; snoops the bus response lines.     |
// |               Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index priority |
// |               instead of round-robin.                                     |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module wb_master_arbiter #(
  parameter int NREQ = 4,
  parameter int dw   = 32,
  parameter int aw   = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*aw-1:0]   req_adr,
  input  logic [NREQ*4-1:0]    req_sel,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*dw-1:0]   req_dat,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 rsp_err,
  output logic [dw-1:0]        rsp_dat,
  output logic                 mst_start,
  output logic [aw-1:0]        mst_adr,
  output logic [3:0]           mst_sel,
  output logic                 mst_we,
  output logic [dw-1:0]        mst_dat,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  input  logic                 wb_rty_i,
  input  logic [dw-1:0]        wb_dat_i
);

  localparam int              LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LW-1:0]   LAST_RST = LW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q,   state_d;
  logic [LW-1:0]       last_q,    last_d;
  logic [LW-1:0]       gidx_q,    gidx_d;
  logic [NREQ-1:0]     grant_q,   grant_d;
  logic [NREQ-1:0]     done_q,    done_d;
  logic                err_q,     err_d;
  logic [dw-1:0]       rdat_q,    rdat_d;
  logic                start_q,   start_d;
  logic [aw-1:0]       adr_q,     adr_d;
  logic [3:0]          sel_q,     sel_d;
  logic                we_q,      we_d;
  logic [dw-1:0]       wdat_q,    wdat_d;

  logic                pick_vld;
  logic [LW-1:0]       pick_idx;
  logic [aw-1:0]       cmd_adr;
  logic [3:0]          cmd_sel;
  logic                cmd_we;
  logic [dw-1:0]       cmd_dat;

`ifdef WB_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest active index is the one left standing.
  always_comb begin : p_select
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_vld = 1'b1;
        pick_idx = LW'(i);
      end
    end
  end
`else
  // Scan offsets NREQ..1 from last grant; the smallest offset wins.
  always_comb begin : p_select
    int rr_idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_idx   = 0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NREQ) begin
        rr_idx = rr_idx - NREQ;
      end
      if (req[rr_idx[LW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx[LW-1:0];
      end
    end
  end
`endif

  always_comb begin : p_cmd_mux
    cmd_adr = '0;
    cmd_sel = '0;
    cmd_we  = 1'b0;
    cmd_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == LW'(i)) begin
        cmd_adr = req_adr[i*aw +: aw];
        cmd_sel = req_sel[i*4 +: 4];
        cmd_we  = req_we[i];
        cmd_dat = req_dat[i*dw +: dw];
      end
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = err_q;
    rdat_d  = rdat_q;
    start_d = 1'b0;
    adr_d   = adr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    wdat_d  = wdat_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
          adr_d             = cmd_adr;
          sel_d             = cmd_sel;
          we_d              = cmd_we;
          wdat_d            = cmd_dat;
          start_d           = 1'b1;
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Error/retry takes precedence over a coincident ack.
        if (wb_err_i || wb_rty_i) begin
          err_d   = 1'b1;
          done_d  = grant_q;
          state_d = S_DONE;
        end else if (wb_ack_i) begin
          err_d   = 1'b0;
          if (!we_q) begin
            rdat_d = wb_dat_i;
          end
          done_d  = grant_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = gidx_q;
        grant_d = '0;
        adr_d   = '0;
        sel_d   = '0;
        we_d    = 1'b0;
        wdat_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      gidx_q  <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      start_q <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      start_q <= start_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      wdat_q  <= wdat_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign rsp_err   = err_q;
  assign rsp_dat   = rdat_q;
  assign mst_start = start_q;
  assign mst_adr   = adr_q;
  assign mst_sel   = sel_q;
  assign mst_we    = we_q;
  assign mst_dat   = wdat_q;

endmodule
`default_nettype wire
